contador_bcd_n: RTL and testbench

Parametrised N-digit BCD up/down counter with an integrated multiplexed 7-segment display driver.
It is the successor to the fixed 3-digit counter and adds:
- programmable digit count, count rate and scan rate
- count direction, enable, synchronous clear and parallel load
- wrap indication and optional leading-zero blanking
It sits under the tile top-level. Segment and anode outputs go to the dedicated and bidirectional pads.

---
 rtl/contador_bcd_n.sv | 174 +++++++++++++++++
 tb/tb_contador_bcd_n.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/contador_bcd_n.sv
// rtl/contador_bcd_n.sv - N-digit BCD up/down counter with multiplexed 7-segment driver
module contador_bcd_n #(
  parameter int DIGITS         = 4,
  parameter int COUNT_DIV      = 1000000,
  parameter int SCAN_DIV       = 1000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int AN_ACTIVE_LOW  = 1,
  parameter int BLANK_LZ       = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  clear,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count_out,
  output logic                  wrap,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int PW = (COUNT_DIV > 1) ? $clog2(COUNT_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [PW-1:0]     PRE_LAST  = PW'(COUNT_DIV - 1);
  localparam logic [SW-1:0]     SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [IW-1:0]     IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [6:0]        SEG_ZERO  = 7'b0111111;
  localparam logic [6:0]        SEG_RST   = (SEG_ACTIVE_LOW != 0) ? ~SEG_ZERO : SEG_ZERO;
  localparam logic [DIGITS-1:0] AN_ONE    = DIGITS'(1);
  localparam logic [DIGITS-1:0] AN_RST    = (AN_ACTIVE_LOW != 0) ? ~AN_ONE : AN_ONE;

  logic [PW-1:0]         pre_q, pre_d;
  logic [4*DIGITS-1:0]   count_q, count_d;
  logic                  wrap_q, wrap_d;
  logic [SW-1:0]         scan_q, scan_d;
  logic [IW-1:0]         idx_q, idx_d;
  logic [6:0]            seg_q, seg_d;
  logic [DIGITS-1:0]     an_q, an_d;

  logic                  tick;
  logic [4*DIGITS-1:0]   load_clamped;
  logic [4*DIGITS-1:0]   count_step;
  logic                  step_carry;
  logic [3:0]            sel_digit;
  logic                  upper_zero;
  logic                  blank;
  logic [6:0]            seg_pat;
  logic [DIGITS-1:0]     an_onehot;

  // Clamp each loaded nibble into the BCD range so count_q never holds a non-decimal digit
  always_comb begin
    load_clamped = '0;
    for (int i = 0; i < DIGITS; i++) begin
      load_clamped[4*i +: 4] = (load_val[4*i +: 4] > 4'd9) ? 4'd9 : load_val[4*i +: 4];
    end
  end

  // Ripple carry/borrow across digits; a carry out of the top digit is the wrap event
  always_comb begin
    count_step = count_q;
    step_carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (step_carry) begin
        if (up_dn) begin
          if (count_q[4*i +: 4] == 4'd9) begin
            count_step[4*i +: 4] = 4'd0;
          end else begin
            count_step[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
            step_carry           = 1'b0;
          end
        end else begin
          if (count_q[4*i +: 4] == 4'd0) begin
            count_step[4*i +: 4] = 4'd9;
          end else begin
            count_step[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
            step_carry           = 1'b0;
          end
        end
      end
    end
  end

  // Prescaler and counter next state: clear beats load beats a counting tick
  always_comb begin
    tick    = (pre_q == PRE_LAST);
    pre_d   = tick ? '0 : pre_q + PW'(1);
    count_d = count_q;
    wrap_d  = 1'b0;
    if (clear) begin
      count_d = '0;
      pre_d   = '0;
    end else if (load) begin
      count_d = load_clamped;
      pre_d   = '0;
    end else if (tick && en) begin
      count_d = count_step;
      wrap_d  = step_carry;
    end
  end

  // Scan timing runs freely, untouched by count controls
  always_comb begin
    scan_d = (scan_q == SCAN_LAST) ? '0 : scan_q + SW'(1);
    idx_d  = idx_q;
    if (scan_q == SCAN_LAST) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
    end
  end

  // Select, blank and decode the current digit; anode and segments are registered together
  always_comb begin
    sel_digit  = 4'd0;
    upper_zero = 1'b1;
    an_onehot  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (i == int'(idx_q)) begin
        sel_digit    = count_q[4*i +: 4];
        an_onehot[i] = 1'b1;
      end
      if (i >= int'(idx_q) && count_q[4*i +: 4] != 4'd0) begin
        upper_zero = 1'b0;
      end
    end
    blank = (BLANK_LZ != 0) && (idx_q != '0) && upper_zero;
    case (sel_digit)
      4'd0:    seg_pat = 7'b0111111;
      4'd1:    seg_pat = 7'b0000110;
      4'd2:    seg_pat = 7'b1011011;
      4'd3:    seg_pat = 7'b1001111;
      4'd4:    seg_pat = 7'b1100110;
      4'd5:    seg_pat = 7'b1101101;
      4'd6:    seg_pat = 7'b1111101;
      4'd7:    seg_pat = 7'b0000111;
      4'd8:    seg_pat = 7'b1111111;
      4'd9:    seg_pat = 7'b1101111;
      default: seg_pat = 7'b0000000;
    endcase
    if (blank) begin
      seg_pat = 7'b0000000;
    end
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_pat : seg_pat;
    an_d  = (AN_ACTIVE_LOW != 0) ? ~an_onehot : an_onehot;
  end

  // All state registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_q   <= '0;
      count_q <= '0;
      wrap_q  <= 1'b0;
      scan_q  <= '0;
      idx_q   <= '0;
      seg_q   <= SEG_RST;
      an_q    <= AN_RST;
    end else begin
      pre_q   <= pre_d;
      count_q <= count_d;
      wrap_q  <= wrap_d;
      scan_q  <= scan_d;
      idx_q   <= idx_d;
      seg_q   <= seg_d;
      an_q    <= an_d;
    end
  end

  assign count_out = count_q;
  assign wrap      = wrap_q;
  assign seg       = seg_q;
  assign an        = an_q;

endmodule

// File: tb/tb_contador_bcd_n.sv
// tb/tb_contador_bcd_n.sv - scoreboard bench for contador_bcd_n
module tb_contador_bcd_n;

  logic        clk      = 1'b0;
  logic        rst      = 1'b0;
  logic        en       = 1'b0;
  logic        up_dn    = 1'b1;
  logic        clear    = 1'b0;
  logic        load     = 1'b0;
  logic [11:0] load_val = '0;
  logic [11:0] count_out;
  logic        wrap;
  logic [6:0]  seg;
  logic [2:0]  an;

  contador_bcd_n #(
    .DIGITS(3), .COUNT_DIV(4), .SCAN_DIV(2),
    .SEG_ACTIVE_LOW(1), .AN_ACTIVE_LOW(1), .BLANK_LZ(1)
  ) dut (
    .clk(clk), .rst(rst), .en(en), .up_dn(up_dn), .clear(clear), .load(load),
    .load_val(load_val), .count_out(count_out), .wrap(wrap), .seg(seg), .an(an)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S5 = 7'b0010010;
  localparam logic [6:0] S7 = 7'b1111000;
  localparam logic [6:0] SB = 7'b1111111;

  typedef struct { logic [11:0] cnt; logic wrap; int gap; } cnt_exp_t;
  typedef struct { logic [2:0] an; logic [6:0] seg; int gap; } disp_exp_t;
  typedef struct { logic [11:0] cnt; logic wrap; bit disp; logic [2:0] an; logic [6:0] seg; } snap_exp_t;

  cnt_exp_t    cnt_q[$];
  disp_exp_t   disp_q[$];
  snap_exp_t   snap_q[$];
  int          checks    = 0;
  int          failures  = 0;
  bit          disp_en   = 1'b0;
  logic [11:0] model_cnt = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  task automatic exp_cnt(input logic [11:0] c, input logic w, input int gap);
    cnt_exp_t e;
    e.cnt = c; e.wrap = w; e.gap = gap;
    cnt_q.push_back(e);
    model_cnt = c;
  endtask

  task automatic exp_disp(input logic [2:0] a, input logic [6:0] s, input int gap);
    disp_exp_t e;
    e.an = a; e.seg = s; e.gap = gap;
    disp_q.push_back(e);
  endtask

  task automatic exp_snap(input logic [11:0] c, input logic w, input bit d, input logic [2:0] a, input logic [6:0] s);
    snap_exp_t e;
    e.cnt = c; e.wrap = w; e.disp = d; e.an = a; e.seg = s;
    snap_q.push_back(e);
  endtask

  function automatic int qsize(input int which);
    if (which == 0) return cnt_q.size();
    if (which == 1) return disp_q.size();
    return snap_q.size();
  endfunction

  task automatic wait_empty(input int which, input int budget);
    int n = 0;
    while (qsize(which) != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (qsize(which) != 0) begin
      checks++;
      failures++;
      $display("FAIL timeout_q%0d: %0d entries left after %0d cycles, want 0", which, qsize(which), budget);
      if (which == 0) cnt_q.delete();
      else if (which == 1) disp_q.delete();
      else snap_q.delete();
    end
  endtask

  task automatic reset_then_load(input logic [11:0] v);
    disp_en = 1'b0; en = 1'b0; load = 1'b0; clear = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    if (model_cnt != 12'h000) exp_cnt(12'h000, 1'b0, 0);
    exp_snap(12'h000, 1'b0, 1'b1, 3'b110, S0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; load = 1'b1; load_val = v; disp_en = 1'b1;
    exp_cnt(v, 1'b0, 0);
    @(negedge clk);
    load = 1'b0;
  endtask

  initial begin : monitor
    logic [11:0] prev_cnt;
    logic [2:0]  prev_an;
    int          cyc, last_cnt_cyc, last_an_cyc;
    cnt_exp_t    ce;
    disp_exp_t   de;
    snap_exp_t   se;
    prev_cnt = '0; prev_an = 3'b110; cyc = 0; last_cnt_cyc = 0; last_an_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (snap_q.size() != 0) begin
        se = snap_q.pop_front();
        check("snap_count", 32'(count_out), 32'(se.cnt));
        check("snap_wrap", 32'(wrap), 32'(se.wrap));
        if (se.disp) begin
          check("snap_an", 32'(an), 32'(se.an));
          check("snap_seg", 32'(seg), 32'(se.seg));
        end
      end
      if (count_out !== prev_cnt || wrap === 1'b1) begin
        if (cnt_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL count_unexpected: got %03h wrap=%0b, want no change", count_out, wrap);
        end else begin
          ce = cnt_q.pop_front();
          check("count", 32'(count_out), 32'(ce.cnt));
          check("wrap", 32'(wrap), 32'(ce.wrap));
          if (ce.gap != 0) check("count_gap", 32'(cyc - last_cnt_cyc), 32'(ce.gap));
        end
        prev_cnt     = count_out;
        last_cnt_cyc = cyc;
      end
      if (an !== prev_an) begin
        if (disp_en) begin
          if (disp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL disp_unexpected: got an=%03b seg=%07b, want no change", an, seg);
          end else begin
            de = disp_q.pop_front();
            check("an", 32'(an), 32'(de.an));
            check("seg", 32'(seg), 32'(de.seg));
            if (de.gap != 0) check("an_gap", 32'(cyc - last_an_cyc), 32'(de.gap));
          end
        end
        prev_an     = an;
        last_an_cyc = cyc;
      end
    end
  end

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    #1;
    rst = 1'b1; en = 1'b1; up_dn = 1'b1;
    exp_snap(12'h000, 1'b0, 1'b1, 3'b110, S0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 1; i <= 100; i++) exp_cnt(bcd(i), 1'b0, (i == 1) ? 0 : 4);
    wait_empty(0, 600);

    load_val = 12'h999; load = 1'b1;
    exp_cnt(12'h999, 1'b0, 0);
    @(negedge clk);
    load = 1'b0;
    exp_cnt(12'h000, 1'b1, 4);
    wait_empty(0, 50);
    up_dn = 1'b0;
    exp_cnt(12'h999, 1'b1, 4);
    wait_empty(0, 50);

    load_val = 12'h3A7; load = 1'b1;
    exp_cnt(12'h397, 1'b0, 0);
    @(negedge clk);
    load = 1'b0;
    wait_empty(0, 50);
    repeat (3) @(negedge clk);
    clear = 1'b1; load = 1'b1; load_val = 12'h555;
    exp_cnt(12'h000, 1'b0, 4);
    @(negedge clk);
    clear = 1'b0; load = 1'b0; en = 1'b0;
    wait_empty(0, 50);

    repeat (20) @(negedge clk);
    exp_snap(12'h000, 1'b0, 1'b0, 3'b000, 7'b0000000);
    wait_empty(2, 10);

    reset_then_load(12'h105);
    exp_disp(3'b101, S0, 0);
    exp_disp(3'b011, S1, 2);
    exp_disp(3'b110, S5, 2);
    exp_disp(3'b101, S0, 2);
    wait_empty(1, 30);
    disp_en = 1'b0;
    wait_empty(0, 10);
    wait_empty(2, 10);

    reset_then_load(12'h007);
    exp_disp(3'b101, SB, 0);
    exp_disp(3'b011, SB, 2);
    exp_disp(3'b110, S7, 2);
    exp_disp(3'b101, SB, 2);
    wait_empty(1, 30);
    disp_en = 1'b0;
    wait_empty(0, 10);
    wait_empty(2, 10);

    up_dn = 1'b1; en = 1'b1;
    exp_cnt(12'h008, 1'b0, 0);
    exp_cnt(12'h009, 1'b0, 4);
    exp_cnt(12'h010, 1'b0, 4);
    wait_empty(0, 40);
    @(negedge clk);
    rst = 1'b1;
    exp_cnt(12'h000, 1'b0, 0);
    exp_snap(12'h000, 1'b0, 1'b1, 3'b110, S0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_cnt(12'h001, 1'b0, 5);
    wait_empty(0, 40);
    wait_empty(2, 10);

    load_val = 12'h100; load = 1'b1;
    exp_cnt(12'h100, 1'b0, 0);
    @(negedge clk);
    load = 1'b0; up_dn = 1'b0;
    exp_cnt(12'h099, 1'b0, 4);
    exp_cnt(12'h098, 1'b0, 4);
    wait_empty(0, 40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
